// File: rtl/rf_wport_arb.sv
// rtl/rf_wport_arb.sv - register-file write port arbiter: pipeline write-back vs buffered long-latency results
module rf_wport_arb #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        p_valid,
  output logic        p_ready,
  input  logic [3:0]  p_we,
  input  logic [4:0]  p_dest,
  input  logic [31:0] p_data,
  input  logic [31:0] p_pc,
  input  logic        l_valid,
  output logic        l_ready,
  input  logic [4:0]  l_dest,
  input  logic [31:0] l_data,
  input  logic [31:0] l_pc,
  output logic [3:0]  rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] dbg_pc,
  output logic        dbg_src,
  output logic [31:0] pend_mask
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]   PTR_ONE    = (AW + 1)'(1);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [4:0]  fifo_dest [FIFO_DEPTH];
  logic [31:0] fifo_data [FIFO_DEPTH];
  logic [31:0] fifo_pc   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] valid_q;

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [SW-1:0] starve_cnt;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic force_fifo;
  logic grant_fifo;
  logic grant_pipe;

  assign wr_idx     = wr_ptr[AW-1:0];
  assign rd_idx     = rd_ptr[AW-1:0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

  assign l_ready = !fifo_full;
  assign push    = l_valid && !fifo_full;

  // Forced grant only when the pipeline is actually competing for the port.
  always_comb begin
    force_fifo = !fifo_empty && p_valid && (starve_cnt == STARVE_LIM);
    grant_fifo = !fifo_empty && (!p_valid || force_fifo);
    grant_pipe = p_valid && !grant_fifo;
  end

  assign pop     = grant_fifo;
  assign p_ready = !force_fifo;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      valid_q    <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr          <= wr_ptr + PTR_ONE;
        valid_q[wr_idx] <= 1'b1;
      end
      if (pop) begin
        rd_ptr          <= rd_ptr + PTR_ONE;
        valid_q[rd_idx] <= 1'b0;
      end
      if (pop || fifo_empty) begin
        starve_cnt <= '0;
      end else if (grant_pipe && (starve_cnt != STARVE_LIM)) begin
        starve_cnt <= starve_cnt + STARVE_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dest[wr_idx] <= l_dest;
      fifo_data[wr_idx] <= l_data;
      fifo_pc[wr_idx]   <= l_pc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_we    <= '0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      dbg_pc   <= '0;
      dbg_src  <= 1'b0;
    end else if (grant_fifo) begin
      rf_we    <= (fifo_dest[rd_idx] == 5'd0) ? 4'h0 : 4'hf;
      rf_waddr <= fifo_dest[rd_idx];
      rf_wdata <= fifo_data[rd_idx];
      dbg_pc   <= fifo_pc[rd_idx];
      dbg_src  <= 1'b1;
    end else if (grant_pipe) begin
      rf_we    <= (p_dest == 5'd0) ? 4'h0 : p_we;
      rf_waddr <= p_dest;
      rf_wdata <= p_data;
      dbg_pc   <= p_pc;
      dbg_src  <= 1'b0;
    end else begin
      rf_we <= '0;
    end
  end

  // r0 is hardwired, so it is never reported as pending.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (valid_q[i]) pend_mask[fifo_dest[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

endmodule
